// File: rtl/input_event_pkg.sv
// rtl/input_event_pkg.sv - shared event codes and word layout for the input event scheduler
package input_event_pkg;

   localparam logic [1:0] EV_PRESS   = 2'b01;
   localparam logic [1:0] EV_RELEASE = 2'b10;
   localparam int         EV_CODE_W  = 2;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter; pointer moves past a requestor only when its grant is used
module rr_arbiter #(
   parameter int N = 32,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req_i,
   input  logic         en_i,
   output logic [N-1:0] gnt_o,
   output logic [W-1:0] gnt_idx_o,
   output logic         grant_valid_o
);

   logic [W-1:0] ptr_q, ptr_d;
   logic [W:0]   slot;
   logic [W-1:0] slot_idx;
   logic         found;

   // Walk the requestors starting at the pointer; the first one set wins.
   always_comb begin
      found     = 1'b0;
      gnt_idx_o = '0;
      slot      = '0;
      slot_idx  = '0;
      for (int k = 0; k < N; k++) begin
         slot = {1'b0, ptr_q} + (W+1)'(k);
         if (slot >= (W+1)'(N)) begin
            slot = slot - (W+1)'(N);
         end
         slot_idx = slot[W-1:0];
         if (!found && req_i[slot_idx]) begin
            found     = 1'b1;
            gnt_idx_o = slot_idx;
         end
      end
   end

   always_comb begin
      grant_valid_o = en_i & found;
      gnt_o         = grant_valid_o ? (N'(1) << gnt_idx_o) : '0;
      ptr_d         = ptr_q;
      if (grant_valid_o) begin
         ptr_d = (gnt_idx_o == W'(N-1)) ? '0 : gnt_idx_o + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/input_event_scheduler.sv
// rtl/input_event_scheduler.sv - edge detect, per-line pending press/release, round-robin drain into a show-ahead event FIFO
module input_event_scheduler
   import input_event_pkg::*;
#(
   parameter int NR    = 16,
   parameter int DEPTH = 8,
   parameter int IDXW  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NR-1:0]             in_clean,
   input  logic                      en,
   output logic                      ev_valid,
   input  logic                      ev_ready,
   output logic [1:0]                ev_code,
   output logic [IDXW-1:0]           ev_idx,
   output logic                      overflow,
   input  logic                      ovf_clr,
   output logic [$clog2(DEPTH):0]    fifo_level
);

   localparam int AW   = $clog2(DEPTH);
   localparam int LW   = AW + 1;
   localparam int WW   = EV_CODE_W + IDXW;
   localparam int NREQ = 2 * NR;
   localparam int GW   = IDXW + 1;

   logic [NR-1:0]   in_q;
   logic            armed_q;
   logic [NR-1:0]   press_pend_q, press_pend_d;
   logic [NR-1:0]   rel_pend_q, rel_pend_d;
   logic            ovf_q, ovf_d;
   logic [WW-1:0]   mem_q [DEPTH];
   logic [AW-1:0]   wptr_q, rptr_q;
   logic [LW-1:0]   count_q, count_d;

   logic [NR-1:0]   rise, fall;
   logic [NR-1:0]   gnt_press, gnt_rel;
   logic [NREQ-1:0] req, gnt;
   logic [GW-1:0]   gnt_idx;
   logic            grant_valid;
   logic            full, pop, push, can_accept, loss;
   logic [WW-1:0]   push_word, head;

   assign rise = (armed_q & en) ? (in_clean & ~in_q) : '0;
   assign fall = (armed_q & en) ? (~in_clean & in_q) : '0;

   // Requestor order interleaves press and release per line: {press0, rel0, press1, rel1, ...}.
   always_comb begin
      req       = '0;
      gnt_press = '0;
      gnt_rel   = '0;
      for (int i = 0; i < NR; i++) begin
         req[2*i]     = press_pend_q[i];
         req[2*i+1]   = rel_pend_q[i];
         gnt_press[i] = gnt[2*i];
         gnt_rel[i]   = gnt[2*i+1];
      end
   end

   assign ev_valid   = (count_q != '0);
   assign full       = (count_q == LW'(DEPTH));
   assign pop        = ev_valid & ev_ready;
   assign can_accept = ~full | pop;
   assign push       = grant_valid;

   rr_arbiter #(
      .N (NREQ),
      .W (GW)
   ) u_arb (
      .clk           (clk),
      .rst           (rst),
      .req_i         (req),
      .en_i          (can_accept),
      .gnt_o         (gnt),
      .gnt_idx_o     (gnt_idx),
      .grant_valid_o (grant_valid)
   );

   assign push_word = {(gnt_idx[0] ? EV_RELEASE : EV_PRESS), gnt_idx[GW-1:1]};

   // A loss is an edge landing on a pending bit that is not being drained this cycle.
   assign loss = |((rise & press_pend_q & ~gnt_press) | (fall & rel_pend_q & ~gnt_rel));

   always_comb begin
      press_pend_d = (press_pend_q & ~gnt_press) | rise;
      rel_pend_d   = (rel_pend_q & ~gnt_rel) | fall;
      ovf_d        = (ovf_q & ~ovf_clr) | loss;
      count_d      = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + LW'(1);
         2'b01:   count_d = count_q - LW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_q         <= '0;
         armed_q      <= 1'b0;
         press_pend_q <= '0;
         rel_pend_q   <= '0;
         ovf_q        <= 1'b0;
         wptr_q       <= '0;
         rptr_q       <= '0;
         count_q      <= '0;
      end else begin
         in_q         <= in_clean;
         armed_q      <= 1'b1;
         press_pend_q <= press_pend_d;
         rel_pend_q   <= rel_pend_d;
         ovf_q        <= ovf_d;
         count_q      <= count_d;
         if (push) begin
            wptr_q <= wptr_q + AW'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= push_word;
      end
   end

   assign head       = mem_q[rptr_q];
   assign ev_code    = ev_valid ? head[WW-1:IDXW] : 2'b00;
   assign ev_idx     = ev_valid ? head[IDXW-1:0] : '0;
   assign overflow   = ovf_q;
   assign fifo_level = count_q;

endmodule

// File: tb/tb_input_event_scheduler.sv
// tb/tb_input_event_scheduler.sv - directed and randomized self-checking bench for input_event_scheduler
module tb_input_event_scheduler;

   logic        clk;
   logic        rst;
   logic [15:0] in_clean;
   logic        en;
   logic        ev_valid;
   logic        ev_ready;
   logic [1:0]  ev_code;
   logic [3:0]  ev_idx;
   logic        overflow;
   logic        ovf_clr;
   logic [3:0]  fifo_level;

   int n_checks;
   int n_fail;

   // Reference model state: pending sets, pointer and an event queue.
   bit          m_armed;
   bit [15:0]   m_inq;
   bit [15:0]   m_press;
   bit [15:0]   m_rel;
   bit          m_ovf;
   int          m_ptr;
   bit [5:0]    m_q[$];

   input_event_scheduler #(.NR(16), .DEPTH(8), .IDXW(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_clean   (in_clean),
      .en         (en),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_code    (ev_code),
      .ev_idx     (ev_idx),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr),
      .fifo_level (fifo_level)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model_reset();
      m_armed = 1'b0;
      m_inq   = '0;
      m_press = '0;
      m_rel   = '0;
      m_ovf   = 1'b0;
      m_ptr   = 0;
      m_q.delete();
   endtask

   // Advance the model by one clock using the currently driven inputs, then clock the DUT.
   task automatic step();
      int        g;
      bit        pop_now;
      bit        can;
      bit        lost;
      bit [15:0] rs, fl, gp, gr;
      pop_now = (m_q.size() > 0) && ev_ready;
      can     = (m_q.size() < 8) || pop_now;
      g       = -1;
      if (can) begin
         for (int k = 0; k < 32; k++) begin
            int r;
            r = (m_ptr + k) % 32;
            if (g < 0 && (((r % 2) == 1) ? m_rel[r/2] : m_press[r/2])) g = r;
         end
      end
      rs = '0;
      fl = '0;
      if (m_armed && en) begin
         rs = in_clean & ~m_inq;
         fl = ~in_clean & m_inq;
      end
      gp = '0;
      gr = '0;
      if (g >= 0) begin
         if ((g % 2) == 1) gr[g/2] = 1'b1;
         else              gp[g/2] = 1'b1;
      end
      lost    = |((rs & m_press & ~gp) | (fl & m_rel & ~gr));
      m_ovf   = (m_ovf && !ovf_clr) || lost;
      m_press = (m_press & ~gp) | rs;
      m_rel   = (m_rel & ~gr) | fl;
      if (pop_now) void'(m_q.pop_front());
      if (g >= 0) begin
         m_q.push_back({(((g % 2) == 1) ? 2'b10 : 2'b01), 4'(g / 2)});
         m_ptr = (g + 1) % 32;
      end
      m_inq   = in_clean;
      m_armed = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input bit [15:0] lvl);
      rst      = 1'b1;
      in_clean = lvl;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      in_clean = 16'h0001;
      en       = 1'b1;
      ev_ready = 1'b0;
      ovf_clr  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      n_checks++;
      if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0d exp=0", ev_valid); end
      n_checks++;
      if (ev_code !== 2'b00) begin n_fail++; $display("FAIL reset_code got=%0d exp=0", ev_code); end
      n_checks++;
      if (ev_idx !== 4'd0) begin n_fail++; $display("FAIL reset_idx got=%0d exp=0", ev_idx); end
      n_checks++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%0d exp=0", overflow); end
      n_checks++;
      if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
   endtask

   task automatic test_arming();
      bit seen;
      seen = 1'b0;
      rst  = 1'b0;
      repeat (20) begin
         step();
         if (ev_valid !== 1'b0) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) begin n_fail++; $display("FAIL arming_no_event got=%0d exp=0", seen); end
      n_checks++;
      if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL arming_level got=%0d exp=0", fifo_level); end
   endtask

   task automatic test_single();
      ev_ready = 1'b1;
      in_clean = 16'h0021;
      step();
      n_checks++;
      if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency_e0 got=%0d exp=0", ev_valid); end
      step();
      n_checks++;
      if (ev_valid !== 1'b1 || ev_code !== 2'b01 || ev_idx !== 4'd5) begin
         n_fail++; $display("FAIL single_press got=v%0d c%0d i%0d exp=v1 c1 i5", ev_valid, ev_code, ev_idx);
      end
      step();
      in_clean = 16'h0001;
      step();
      step();
      n_checks++;
      if (ev_valid !== 1'b1 || ev_code !== 2'b10 || ev_idx !== 4'd5) begin
         n_fail++; $display("FAIL single_release got=v%0d c%0d i%0d exp=v1 c2 i5", ev_valid, ev_code, ev_idx);
      end
      step();
      n_checks++;
      if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained got=%0d exp=0", ev_valid); end
   endtask

   task automatic test_simultaneous();
      bit [3:0] exp_idx [3];
      exp_idx[0] = 4'd3;
      exp_idx[1] = 4'd7;
      exp_idx[2] = 4'd12;
      apply_reset(16'h0000);
      ev_ready = 1'b1;
      in_clean = 16'h1088;
      step();
      for (int n = 0; n < 3; n++) begin
         step();
         n_checks++;
         if (ev_valid !== 1'b1 || ev_code !== 2'b01 || ev_idx !== exp_idx[n]) begin
            n_fail++; $display("FAIL simul_order%0d got=v%0d c%0d i%0d exp=v1 c1 i%0d", n, ev_valid, ev_code, ev_idx, exp_idx[n]);
         end
      end
      step();
      n_checks++;
      if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL simul_drained got=%0d exp=0", ev_valid); end
   endtask

   task automatic test_backpressure();
      apply_reset(16'h0000);
      ev_ready = 1'b0;
      in_clean = 16'h01FF;
      repeat (11) step();
      n_checks++;
      if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL bp_level got=%0d exp=8", fifo_level); end
      n_checks++;
      if (ev_idx !== 4'd0 || ev_code !== 2'b01) begin n_fail++; $display("FAIL bp_head got=c%0d i%0d exp=c1 i0", ev_code, ev_idx); end
      n_checks++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_no_ovf got=%0d exp=0", overflow); end
      in_clean = 16'h00FF;
      step();
      n_checks++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_fall_no_ovf got=%0d exp=0", overflow); end
      in_clean = 16'h01FF;
      step();
      n_checks++;
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_ovf_set got=%0d exp=1", overflow); end
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      n_checks++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_ovf_clr got=%0d exp=0", overflow); end
   endtask

   task automatic test_full_pop();
      ev_ready = 1'b1;
      step();
      n_checks++;
      if (fifo_level !== 4'd8 || ev_idx !== 4'd1) begin
         n_fail++; $display("FAIL fullpop_first got=l%0d i%0d exp=l8 i1", fifo_level, ev_idx);
      end
      step();
      n_checks++;
      if (fifo_level !== 4'd8 || ev_idx !== 4'd2) begin
         n_fail++; $display("FAIL fullpop_second got=l%0d i%0d exp=l8 i2", fifo_level, ev_idx);
      end
      repeat (6) step();
      n_checks++;
      if (ev_code !== 2'b01 || ev_idx !== 4'd8) begin
         n_fail++; $display("FAIL fullpop_press8 got=c%0d i%0d exp=c1 i8", ev_code, ev_idx);
      end
      step();
      n_checks++;
      if (ev_code !== 2'b10 || ev_idx !== 4'd8) begin
         n_fail++; $display("FAIL fullpop_rel8 got=c%0d i%0d exp=c2 i8", ev_code, ev_idx);
      end
      step();
      n_checks++;
      if (fifo_level !== 4'd0 || ev_valid !== 1'b0) begin
         n_fail++; $display("FAIL fullpop_drained got=l%0d v%0d exp=l0 v0", fifo_level, ev_valid);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      apply_reset(16'h0000);
      ev_ready = 1'b0;
      in_clean = 16'h000F;
      repeat (6) step();
      n_checks++;
      if (fifo_level !== 4'd4) begin n_fail++; $display("FAIL rmid_fill got=%0d exp=4", fifo_level); end
      in_clean = 16'hFFFF;
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (ev_valid !== 1'b0 || fifo_level !== 4'd0) begin
         n_fail++; $display("FAIL rmid_async got=v%0d l%0d exp=v0 l0", ev_valid, fifo_level);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst      = 1'b0;
      ev_ready = 1'b1;
      seen     = 1'b0;
      repeat (20) begin
         step();
         if (ev_valid !== 1'b0) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) begin n_fail++; $display("FAIL rmid_no_press got=%0d exp=0", seen); end
   endtask

   task automatic test_random();
      int bad_valid, bad_level, bad_ovf, bad_head;
      bad_valid = 0;
      bad_level = 0;
      bad_ovf   = 0;
      bad_head  = 0;
      apply_reset(16'($urandom));
      for (int b = 0; b < 6; b++) begin
         for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 2) == 0) in_clean = in_clean ^ (16'(1) << $urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) in_clean = in_clean ^ 16'($urandom);
            en       = ($urandom_range(0, 7) != 0);
            ev_ready = (b % 3 == 0) ? ($urandom_range(0, 3) == 0) :
                       (b % 3 == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) != 0);
            ovf_clr  = ($urandom_range(0, 31) == 0);
            step();
            n_checks++;
            if (ev_valid !== (m_q.size() > 0)) begin
               n_fail++; bad_valid++;
               if (bad_valid < 4) $display("FAIL rand_valid got=%0d exp=%0d", ev_valid, m_q.size() > 0);
            end
            n_checks++;
            if (fifo_level !== 4'(m_q.size())) begin
               n_fail++; bad_level++;
               if (bad_level < 4) $display("FAIL rand_level got=%0d exp=%0d", fifo_level, m_q.size());
            end
            n_checks++;
            if (overflow !== m_ovf) begin
               n_fail++; bad_ovf++;
               if (bad_ovf < 4) $display("FAIL rand_overflow got=%0d exp=%0d", overflow, m_ovf);
            end
            if (m_q.size() > 0) begin
               n_checks++;
               if ({ev_code, ev_idx} !== m_q[0]) begin
                  n_fail++; bad_head++;
                  if (bad_head < 4) $display("FAIL rand_head got=c%0d i%0d exp=c%0d i%0d", ev_code, ev_idx, m_q[0][5:4], m_q[0][3:0]);
               end
            end
         end
      end
      en      = 1'b1;
      ovf_clr = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      in_clean = '0;
      en       = 1'b1;
      ev_ready = 1'b0;
      ovf_clr  = 1'b0;
      model_reset();
      test_reset();
      test_arming();
      test_single();
      test_simultaneous();
      test_backpressure();
      test_full_pop();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/input_event_scheduler.md
# input_event_scheduler

Turns the debounced button/switch vector into an ordered stream of discrete press/release events for the control logic. It sits directly behind the input debouncer bank. It detects edges on every line and keeps per-line pending press and release requests. A round-robin arbiter drains those requests one per cycle into an event FIFO. A valid/ready port delivers the events to the consumer.

## Interface
- `NR`, 16, number of debounced input lines.
- `DEPTH`, 8, event FIFO depth; power of two, ≥2.
- `IDXW`, 4, index width; must equal clog2(`NR`).
- `clk` in 1: the single clock; all state is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_clean` in `NR`: debounced levels, already synchronous to `clk`.
- `en` in 1: when 0, new edges are not recorded; pending requests and the FIFO still drain.
- `ev_valid` out 1: the FIFO head is valid.
- `ev_ready` in 1: the consumer accepts the head.
- `ev_code` out 2: event type; 01 = press (rising edge), 10 = release (falling edge).
- `ev_idx` out `IDXW`: line index of the event.
- `overflow` out 1: sticky flag; at least one event was lost.
- `ovf_clr` in 1: clears `overflow` on the next edge.
- `fifo_level` out clog2(`DEPTH`)+1: current FIFO occupancy.

## Operation
- **Reset values**
  - `ev_valid`=0, `ev_code`=0, `ev_idx`=0, `overflow`=0, `fifo_level`=0.
  - All pending requests are cleared, the arbiter pointer is 0, and `armed`=0.
- **Arming**
  - The first edge after reset deasserts loads `in_q` ← `in_clean`, sets `armed`=1 and generates no events.
  - A line held high through reset therefore never produces a spurious press.
- **Edge detect** (only when `armed` & `en`)
  - rise[i] = `in_clean`[i] & ~`in_q`[i]; fall[i] = ~`in_clean`[i] & `in_q`[i].
  - `in_q` follows `in_clean` every cycle regardless of `en`.
- **Pending requests**
  - Per line, `press_pend`[i] is set by rise[i] and `rel_pend`[i] is set by fall[i].
  - A bit is cleared when its request is granted.
  - If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- **Lost events**
  - An edge arriving while the corresponding pending bit is already 1, and that bit is not granted this cycle, sets `overflow`.
  - `ovf_clr` and a new loss in the same cycle: the set wins.
- **Arbitration**
  - 2·`NR` requestors, ordered {press0, rel0, press1, rel1, …}.
  - Round-robin: search starts at pointer `ptr`; on a grant to requestor g, `ptr` ← g+1 mod 2·`NR`.
  - At most one grant per cycle.
  - A grant happens only if the FIFO can accept: not full, or full with a pop in the same cycle.
  - The granted word {code, idx} is written to the FIFO tail at the edge.
- **Ordering**
  - Press and release on the same line are separate requestors.
  - If both are pending, the one whose slot the pointer reaches first goes first.
  - Rapid toggling under backpressure can therefore reorder the two events; `overflow` reports any lost edge, not this reordering.
- **FIFO**
  - Show-ahead: the head appears on `ev_*` whenever `fifo_level`>0.
  - Pop on `ev_valid` & `ev_ready`.
  - Push and pop in the same cycle leave `fifo_level` unchanged.
  - Read and write pointers are clog2(`DEPTH`) bits and wrap naturally.
- **Consumer rules**
  - `ev_code` and `ev_idx` hold stable while `ev_valid` & ~`ev_ready`.
  - `ev_ready` is ignored when `ev_valid`=0.

## Timing
- Edge to `ev_valid`:
  - `in_clean` changes before edge E0; pending is set at E0; FIFO write at E1; `ev_valid`=1 after E1.
  - Latency is 2 cycles with an empty FIFO and no competing requests.
- Sustained throughput is 1 event/cycle with `ev_ready` held high.
- `ev_ready` has no combinational path to the grant other than the full-and-pop case.
- `ev_valid` is driven directly from FIFO state; there is no combinational path from `ev_ready` to `ev_valid`.
- Asynchronous `rst` mid-operation drops the FIFO contents and all pending requests immediately; re-arming follows the arming rule.

## Structure
- Shared package `input_event_pkg`:
  - `EV_PRESS`=2'b01, `EV_RELEASE`=2'b10.
  - Event word width = 2+`IDXW`.
- Sub-module `rr_arbiter`:
  - Parameter `N`.
  - Ports: request vector, enable, one-hot grant, encoded grant index, `grant_valid`.
  - Holds its own pointer; the pointer advances only when the grant is used.
- The FIFO, edge detect and pending logic are inline.

## Test plan
- **Arming:** `in_clean`=16'h0001 held through reset → no event, `ev_valid` stays 0 for 20 cycles.
- **Single press/release:**
  - Line 5 rises at E0 → `ev_valid` after E1 with code 01, idx 5.
  - Line 5 then falls → code 10, idx 5.
- **Simultaneous edges:** lines 3, 7 and 12 rise in one cycle with `ptr`=0 and `ev_ready`=1 → three events in order idx 3, 7, 12 on consecutive cycles.
- **Backpressure and overflow:**
  - `ev_ready`=0 and 9 distinct lines rise → `fifo_level`=8 and 1 request stays pending; `overflow` stays 0.
  - That pending line falls and rises again before being granted → `overflow`=1.
  - `ovf_clr` → `overflow`=0 on the next edge.
- **Full with concurrent pop:** FIFO full, `ev_ready`=1 and a pending request present → push and pop in the same cycle, `fifo_level` stays 8, no stall.
- **Reset mid-operation:** `rst` asserted with `fifo_level`=4 → `ev_valid`=0 and `fifo_level`=0 immediately; after release, lines held high generate no presses.
